umi_adder_ctrl: RTL and testbench

Host-side sequencer that drives a UMI adder device over its UMI device port. It accepts one operand pair at a time, writes operand A and operand B to the device, reads back the sum, and returns the sum (or an error) on a valid/ready result port. It sits between local logic and the adder's `udev_req_*`/`udev_resp_*` ports, so software-free logic can use the adder as a shared arithmetic resource.

---
 rtl/umi_adder_ctrl.sv | 207 ++++++++++++++++++++
 tb/tb_umi_adder_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/umi_adder_ctrl.sv
// umi_adder_ctrl: host-side sequencer for a UMI adder device.
// Takes one operand pair and writes A, then writes B. It then reads C and
// returns the sum, or an error, on a valid/ready result port.
module umi_adder_ctrl #(
    parameter int              CW      = 32,
    parameter int              AW      = 64,
    parameter int              DW      = 32,
    parameter logic [AW-1:0]   BASE    = '0,
    parameter logic [AW-1:0]   SRCADDR = '0,
    parameter int              TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          reset,
    // operand port
    input  logic          op_valid,
    input  logic [DW-1:0] op_a,
    input  logic [DW-1:0] op_b,
    output logic          op_ready,
    // result port
    output logic          res_valid,
    output logic [DW-1:0] res_data,
    output logic          res_err,
    input  logic          res_ready,
    output logic          busy,
    // UMI request
    output logic          uhost_req_valid,
    output logic [CW-1:0] uhost_req_cmd,
    output logic [AW-1:0] uhost_req_dstaddr,
    output logic [AW-1:0] uhost_req_srcaddr,
    output logic [DW-1:0] uhost_req_data,
    input  logic          uhost_req_ready,
    // UMI response
    input  logic          uhost_resp_valid,
    input  logic [CW-1:0] uhost_resp_cmd,
    input  logic [AW-1:0] uhost_resp_dstaddr,
    input  logic [AW-1:0] uhost_resp_srcaddr,
    input  logic [DW-1:0] uhost_resp_data,
    output logic          uhost_resp_ready
);

    localparam logic [4:0] OP_REQ_RD  = 5'h01;
    localparam logic [4:0] OP_REQ_WR  = 5'h03;
    localparam logic [4:0] OP_RESP_RD = 5'h02;
    localparam logic [4:0] OP_RESP_WR = 5'h04;
    localparam logic [2:0] SIZE       = 3'($clog2(DW / 8));
    localparam int         TW         = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_A, S_WAIT_A, S_WR_B, S_WAIT_B, S_RD_C, S_WAIT_C, S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] op_a_q, op_a_d;
    logic [DW-1:0] op_b_q, op_b_d;
    logic [DW-1:0] res_data_q, res_data_d;
    logic          err_q, err_d;
    logic [TW-1:0] wait_cnt_q, wait_cnt_d;

    logic          req_hs;
    logic          resp_hs;
    logic [31:0]   wait_cnt_nxt;
    logic          timeout_hit;
    logic          unused_resp;

    // Only the opcode of a response matters; routing fields are ignored.
    assign unused_resp = ^{uhost_resp_cmd[CW-1:5], uhost_resp_dstaddr, uhost_resp_srcaddr};

    assign req_hs       = uhost_req_valid && uhost_req_ready;
    assign resp_hs      = uhost_resp_valid && uhost_resp_ready;
    assign wait_cnt_nxt = 32'(wait_cnt_q) + 32'd1;
    assign timeout_hit  = (TIMEOUT != 0) && (wait_cnt_nxt == 32'(TIMEOUT));

    function automatic logic [CW-1:0] mk_cmd(input logic [4:0] opcode);
        logic [CW-1:0] c;
        c      = '0;
        c[4:0] = opcode;
        c[7:5] = SIZE;
        return c;
    endfunction

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            res_data_q <= '0;
            err_q      <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            res_data_q <= res_data_d;
            err_q      <= err_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Next-state logic: write A, write B, read C, with per-wait timeout.
    always_comb begin
        logic [4:0] exp_op;
        state_t     ok_next;
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        res_data_d = res_data_q;
        err_d      = err_q;
        wait_cnt_d = wait_cnt_q;
        exp_op     = OP_RESP_WR;
        ok_next    = S_DONE;
        case (state_q)
            S_WAIT_A: ok_next = S_WR_B;
            S_WAIT_B: ok_next = S_RD_C;
            S_WAIT_C: begin
                exp_op  = OP_RESP_RD;
                ok_next = S_DONE;
            end
            default: ;
        endcase
        case (state_q)
            S_IDLE: begin
                if (op_valid && op_ready) begin
                    op_a_d     = op_a;
                    op_b_d     = op_b;
                    err_d      = 1'b0;
                    res_data_d = '0;
                    state_d    = S_WR_A;
                end
            end
            S_WR_A, S_WR_B, S_RD_C: begin
                if (req_hs) begin
                    wait_cnt_d = '0;
                    state_d    = (state_q == S_WR_A) ? S_WAIT_A :
                                 (state_q == S_WR_B) ? S_WAIT_B : S_WAIT_C;
                end
            end
            S_WAIT_A, S_WAIT_B, S_WAIT_C: begin
                if (resp_hs) begin
                    if (uhost_resp_cmd[4:0] == exp_op) begin
                        state_d = ok_next;
                        if (state_q == S_WAIT_C) begin
                            res_data_d = uhost_resp_data;
                        end
                    end else begin
                        err_d      = 1'b1;
                        res_data_d = '0;
                        state_d    = S_DONE;
                    end
                end else if (timeout_hit) begin
                    err_d      = 1'b1;
                    res_data_d = '0;
                    state_d    = S_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TW'(1);
                end
            end
            S_DONE: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode; request fields are zero whenever no request is offered.
    always_comb begin
        op_ready          = (state_q == S_IDLE) && !reset;
        busy              = (state_q != S_IDLE);
        res_valid         = (state_q == S_DONE);
        res_data          = res_data_q;
        res_err           = err_q;
        uhost_req_valid   = 1'b0;
        uhost_req_cmd     = '0;
        uhost_req_dstaddr = '0;
        uhost_req_srcaddr = '0;
        uhost_req_data    = '0;
        uhost_resp_ready  = !reset && (state_q == S_IDLE   || state_q == S_DONE   ||
                                       state_q == S_WAIT_A || state_q == S_WAIT_B ||
                                       state_q == S_WAIT_C);
        case (state_q)
            S_WR_A: begin
                uhost_req_valid   = 1'b1;
                uhost_req_cmd     = mk_cmd(OP_REQ_WR);
                uhost_req_dstaddr = BASE;
                uhost_req_srcaddr = SRCADDR;
                uhost_req_data    = op_a_q;
            end
            S_WR_B: begin
                uhost_req_valid   = 1'b1;
                uhost_req_cmd     = mk_cmd(OP_REQ_WR);
                uhost_req_dstaddr = BASE + AW'('h08);
                uhost_req_srcaddr = SRCADDR;
                uhost_req_data    = op_b_q;
            end
            S_RD_C: begin
                uhost_req_valid   = 1'b1;
                uhost_req_cmd     = mk_cmd(OP_REQ_RD);
                uhost_req_dstaddr = BASE + AW'('h10);
                uhost_req_srcaddr = SRCADDR;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_umi_adder_ctrl.sv
// Testbench for umi_adder_ctrl: a UMI adder device model with configurable
// stalls, delays and faults, plus an arithmetic reference for results.
module tb_umi_adder_ctrl;

    localparam int            CW      = 32;
    localparam int            AW      = 64;
    localparam int            DW      = 32;
    localparam int            TIMEOUT = 8;
    localparam logic [AW-1:0] BASE    = 64'h0000_0000_0000_1000;
    localparam logic [AW-1:0] SRCADDR = 64'h0000_ABCD_0000_1234;

    logic          clk = 1'b0;
    logic          reset;
    logic          op_valid, op_ready;
    logic [DW-1:0] op_a, op_b;
    logic          res_valid, res_err, res_ready, busy;
    logic [DW-1:0] res_data;
    logic          uhost_req_valid, uhost_req_ready;
    logic [CW-1:0] uhost_req_cmd;
    logic [AW-1:0] uhost_req_dstaddr, uhost_req_srcaddr;
    logic [DW-1:0] uhost_req_data;
    logic          uhost_resp_valid, uhost_resp_ready;
    logic [CW-1:0] uhost_resp_cmd;
    logic [AW-1:0] uhost_resp_dstaddr, uhost_resp_srcaddr;
    logic [DW-1:0] uhost_resp_data;

    umi_adder_ctrl #(
        .CW(CW), .AW(AW), .DW(DW), .BASE(BASE), .SRCADDR(SRCADDR), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .op_valid(op_valid), .op_a(op_a), .op_b(op_b), .op_ready(op_ready),
        .res_valid(res_valid), .res_data(res_data), .res_err(res_err),
        .res_ready(res_ready), .busy(busy),
        .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
        .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
        .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
        .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
        .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
        .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- device model ----------------
    int            cfg_stall = 0;
    int            cfg_delay = 0;
    bit            cfg_drop_b = 0;
    bit            cfg_bad_a = 0;
    int            drained = 0;

    logic [CW-1:0] log_cmd[$];
    logic [AW-1:0] log_dst[$];
    logic [AW-1:0] log_src[$];
    logic [DW-1:0] log_data[$];
    int            log_cyc[$];

    initial begin
        bit            req_hs_p, resp_hs_p, pend, held;
        int            pend_dly, stall_cnt, cap_cyc;
        logic [CW-1:0] pend_cmd, cap_cmd, h_cmd;
        logic [DW-1:0] pend_data, cap_data, h_data, mem_a, mem_b;
        logic [AW-1:0] cap_dst, cap_src, h_dst;
        req_hs_p = 0; resp_hs_p = 0; pend = 0; held = 0;
        pend_dly = 0; stall_cnt = 0; cap_cyc = 0;
        pend_cmd = '0; pend_data = '0; mem_a = '0; mem_b = '0;
        cap_cmd = '0; cap_data = '0; cap_dst = '0; cap_src = '0;
        h_cmd = '0; h_data = '0; h_dst = '0;
        uhost_req_ready    = 1'b0;
        uhost_resp_valid   = 1'b0;
        uhost_resp_cmd     = '0;
        uhost_resp_dstaddr = '0;
        uhost_resp_srcaddr = '0;
        uhost_resp_data    = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                pend = 0; held = 0; stall_cnt = 0;
                req_hs_p = 0; resp_hs_p = 0;
                uhost_resp_valid = 1'b0;
                uhost_req_ready  = 1'b0;
            end else begin
                if (resp_hs_p) begin
                    uhost_resp_valid = 1'b0;
                    pend = 0;
                end
                if (req_hs_p) begin
                    log_cmd.push_back(cap_cmd);
                    log_dst.push_back(cap_dst);
                    log_src.push_back(cap_src);
                    log_data.push_back(cap_data);
                    log_cyc.push_back(cap_cyc);
                    pend_dly  = cfg_delay;
                    pend_data = '0;
                    if (cap_cmd[4:0] == 5'h03) begin
                        pend_cmd = 32'h44;
                        if (cap_dst == BASE) begin
                            mem_a = cap_data;
                            if (cfg_bad_a) pend_cmd = 32'h42;
                        end else if (cap_dst == BASE + 64'h8) begin
                            mem_b = cap_data;
                            if (cfg_drop_b) pend_dly = 20;
                        end
                    end else begin
                        pend_cmd  = 32'h42;
                        pend_data = mem_a + mem_b;
                    end
                    pend = 1;
                    stall_cnt = 0;
                end
                if (pend && !uhost_resp_valid) begin
                    if (pend_dly == 0) begin
                        uhost_resp_valid   = 1'b1;
                        uhost_resp_cmd     = pend_cmd;
                        uhost_resp_data    = pend_data;
                        uhost_resp_dstaddr = SRCADDR;
                        uhost_resp_srcaddr = BASE;
                    end else begin
                        pend_dly--;
                    end
                end
                uhost_req_ready = (stall_cnt >= cfg_stall);
                if (uhost_req_valid && !uhost_req_ready) stall_cnt++;
                #1;
                if (held) begin
                    check_val("req_valid_hold", 64'(uhost_req_valid), 64'd1);
                    check_val("req_cmd_hold", 64'(uhost_req_cmd), 64'(h_cmd));
                    check_val("req_dst_hold", uhost_req_dstaddr, h_dst);
                    check_val("req_data_hold", 64'(uhost_req_data), 64'(h_data));
                end
                held      = uhost_req_valid && !uhost_req_ready;
                h_cmd     = uhost_req_cmd;
                h_dst     = uhost_req_dstaddr;
                h_data    = uhost_req_data;
                req_hs_p  = uhost_req_valid && uhost_req_ready;
                resp_hs_p = uhost_resp_valid && uhost_resp_ready;
                cap_cmd   = uhost_req_cmd;
                cap_dst   = uhost_req_dstaddr;
                cap_src   = uhost_req_srcaddr;
                cap_data  = uhost_req_data;
                cap_cyc   = cyc;
                if (resp_hs_p && !busy) drained++;
            end
        end
    end

    // ---------------- one operation ----------------
    // kind: 0 = normal sum, 1 = B write never answered, 2 = A write answered with RESP_RD
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int hold,
                          input int kind, input bit chk_lat);
        int            base_idx, c0, t_done, guard, n_req;
        logic [31:0]   exp_data;
        logic [CW-1:0] exp_cmd;
        logic [DW-1:0] exp_wdata;
        base_idx = log_cmd.size();
        exp_data = (kind == 0) ? (a + b) : 32'd0;
        @(negedge clk);
        op_valid = 1'b1; op_a = a; op_b = b;
        guard = 0;
        while (!op_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("op_accept", 64'(op_ready), 64'd1);
        c0 = cyc;
        @(negedge clk);
        op_valid = 1'b0;
        op_a = $urandom; op_b = $urandom;
        guard = 0;
        while (!res_valid && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check_val("res_valid", 64'(res_valid), 64'd1);
        t_done = cyc;
        check_val("res_data", 64'(res_data), 64'(exp_data));
        check_val("res_err", 64'(res_err), (kind != 0) ? 64'd1 : 64'd0);
        if (chk_lat) check_val("latency", 64'(t_done - c0), 64'd7);
        n_req = (kind == 0) ? 3 : (kind == 1) ? 2 : 1;
        check_val("req_count", 64'(log_cmd.size() - base_idx), 64'(n_req));
        if (kind == 1 && log_cyc.size() >= base_idx + 2)
            check_val("timeout_cycle", 64'(t_done), 64'(log_cyc[base_idx + 1] + TIMEOUT + 1));
        for (int i = 0; i < n_req && base_idx + i < log_cmd.size(); i++) begin
            exp_cmd      = '0;
            exp_cmd[4:0] = (i == 2) ? 5'h01 : 5'h03;
            exp_cmd[7:5] = 3'd2;
            exp_wdata    = (i == 0) ? a : (i == 1) ? b : 32'd0;
            check_val("req_cmd", 64'(log_cmd[base_idx + i]), 64'(exp_cmd));
            check_val("req_dst", log_dst[base_idx + i], BASE + 64'(8 * i));
            check_val("req_src", log_src[base_idx + i], SRCADDR);
            check_val("req_data", 64'(log_data[base_idx + i]), 64'(exp_wdata));
        end
        for (int i = 0; i < hold; i++) begin
            res_ready = 1'b0;
            @(negedge clk);
            check_val("res_hold_valid", 64'(res_valid), 64'd1);
            check_val("res_hold_data", 64'(res_data), 64'(exp_data));
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        check_val("idle_op_ready", 64'(op_ready), 64'd1);
        check_val("idle_res_valid", 64'(res_valid), 64'd0);
        $display("op a=0x%08h b=0x%08h kind=%0d -> data=0x%08h err=%0b (exp 0x%08h) at cycle %0d",
                 a, b, kind, res_data, res_err, exp_data, t_done);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int base_idx, guard, d0;
        reset = 1'b1; op_valid = 1'b0; op_a = '0; op_b = '0; res_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_ctl", 64'({op_ready, busy, res_valid, res_err, uhost_req_valid, uhost_resp_ready}), 64'd0);
        check_val("rst_cmd", 64'(uhost_req_cmd), 64'd0);
        check_val("rst_dst", uhost_req_dstaddr, 64'd0);
        check_val("rst_res_data", 64'(res_data), 64'd0);
        reset = 1'b0;
        #1;
        check_val("rst_release_op_ready", 64'(op_ready), 64'd1);

        // basic, wrap-around
        run_op(32'd3, 32'd5, 0, 0, 1);
        run_op(32'hFFFF_FFFF, 32'd2, 0, 0, 1);

        // request stalls and result back-pressure
        cfg_stall = 4;
        run_op(32'h1234_5678, 32'h0101_0101, 3, 0, 0);
        cfg_stall = 0;

        // B write never answered; late response drained in IDLE
        cfg_drop_b = 1;
        d0 = drained;
        run_op(32'd100, 32'd200, 0, 1, 0);
        guard = 0;
        while (drained == d0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("late_drained", 64'(drained - d0), 64'd1);
        cfg_drop_b = 0;
        run_op(32'd7, 32'd9, 0, 0, 1);

        // A write answered with the wrong opcode
        cfg_bad_a = 1;
        run_op(32'd11, 32'd22, 2, 2, 0);
        cfg_bad_a = 0;

        // reset while waiting for the C read response
        cfg_delay = 5;
        base_idx = log_cmd.size();
        @(negedge clk);
        op_valid = 1'b1; op_a = 32'd1; op_b = 32'd2;
        @(negedge clk);
        op_valid = 1'b0;
        guard = 0;
        while (log_cmd.size() < base_idx + 3 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check_val("reached_wait_c", 64'(log_cmd.size() - base_idx), 64'd3);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_ctl", 64'({op_ready, busy, res_valid, res_err, uhost_req_valid, uhost_resp_ready}), 64'd0);
        check_val("midrst_cmd", 64'(uhost_req_cmd), 64'd0);
        check_val("midrst_src", uhost_req_srcaddr, 64'd0);
        check_val("midrst_data", 64'({uhost_req_data, res_data}), 64'd0);
        reset = 1'b0;
        cfg_delay = 0;
        #1;
        check_val("midrst_op_ready", 64'(op_ready), 64'd1);
        run_op(32'd10, 32'd20, 0, 0, 1);

        // randomized traffic
        for (int n = 0; n < 20; n++) begin
            cfg_stall = int'($urandom_range(0, 3));
            cfg_delay = int'($urandom_range(0, 3));
            run_op($urandom, $urandom, int'($urandom_range(0, 3)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

endmodule
